// File: rtl/pdm_cic_decimator.sv
// PDM-to-PCM CIC decimator: ORDER integrators at the PDM strobe rate, ORDER
// pipelined comb stages at the decimated rate, and a valid/ready output register.
module pdm_cic_decimator #(
  parameter int ORDER      = 3,
  parameter int DECIMATION = 64,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                        wbs_clk_i,
  input  logic                        wbs_rst_i,
  input  logic                        pdm_stb,
  input  logic                        pdm_dat,
  output logic signed [OUT_WIDTH-1:0] pcm_dat,
  output logic                        pcm_valid,
  input  logic                        pcm_ready,
  output logic                        overrun,
  input  logic                        overrun_clr
);

  localparam int LOG2D = $clog2(DECIMATION);
  localparam int W     = ORDER * LOG2D + 2;

  if (ORDER < 1 || ORDER > 5) begin : g_bad_order
    $error("pdm_cic_decimator: ORDER must be 1..5");
  end
  if (DECIMATION < 2 || (1 << LOG2D) != DECIMATION) begin : g_bad_dec
    $error("pdm_cic_decimator: DECIMATION must be a power of two >= 2");
  end
  if (W < OUT_WIDTH) begin : g_bad_width
    $error("pdm_cic_decimator: internal width smaller than OUT_WIDTH");
  end

  // Handshake: a sample moves to the consumer on any cycle where pcm_valid and
  // pcm_ready are both high; pcm_dat stays put while pcm_valid=1 until then,
  // unless a newer sample overwrites it, which raises the sticky overrun flag.

  logic [LOG2D-1:0] r_cnt;
  logic [W-1:0]     r_integ [ORDER];
  logic             r_dec;
  logic [W-1:0]     r_cap;
  logic             r_cap_v;
  logic [W-1:0]     r_comb  [ORDER];
  logic [W-1:0]     r_prev  [ORDER];
  logic             r_cv    [ORDER];

  logic             w_dec;
  logic [W-1:0]     w_in;
  logic [W-1:0]     w_cx    [ORDER];
  logic             w_cxv   [ORDER];
  logic             w_new;

  assign w_dec = pdm_stb && (r_cnt == LOG2D'(DECIMATION - 1));
  assign w_in  = pdm_dat ? W'(1) : {W{1'b1}};
  assign w_new = r_cv[ORDER-1];

  always_comb begin
    w_cx[0]  = r_cap;
    w_cxv[0] = r_cap_v;
    for (int k = 1; k < ORDER; k++) begin
      w_cx[k]  = r_comb[k-1];
      w_cxv[k] = r_cv[k-1];
    end
  end

  // Integrators all see the previous-cycle values of their predecessor.
  always_ff @(posedge wbs_clk_i) begin
    if (wbs_rst_i) begin
      r_cnt <= '0;
      r_dec <= 1'b0;
      for (int k = 0; k < ORDER; k++) r_integ[k] <= '0;
    end else begin
      r_dec <= w_dec;
      if (pdm_stb) begin
        r_cnt      <= r_cnt + LOG2D'(1);
        r_integ[0] <= r_integ[0] + w_in;
        for (int k = 1; k < ORDER; k++) r_integ[k] <= r_integ[k] + r_integ[k-1];
      end
    end
  end

  // Capture one cycle after the decimation strobe so its contribution is in.
  always_ff @(posedge wbs_clk_i) begin
    if (wbs_rst_i) begin
      r_cap   <= '0;
      r_cap_v <= 1'b0;
      for (int k = 0; k < ORDER; k++) begin
        r_comb[k] <= '0;
        r_prev[k] <= '0;
        r_cv[k]   <= 1'b0;
      end
    end else begin
      r_cap_v <= r_dec;
      if (r_dec) r_cap <= r_integ[ORDER-1];
      for (int k = 0; k < ORDER; k++) begin
        r_cv[k] <= w_cxv[k];
        if (w_cxv[k]) begin
          r_comb[k] <= w_cx[k] - r_prev[k];
          r_prev[k] <= w_cx[k];
        end
      end
    end
  end

  // Arithmetic shift by W-OUT_WIDTH then truncation is just the top bits.
  always_ff @(posedge wbs_clk_i) begin
    if (wbs_rst_i) begin
      pcm_dat   <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (w_new) begin
      pcm_dat   <= $signed(r_comb[ORDER-1][W-1 -: OUT_WIDTH]);
      pcm_valid <= 1'b1;
      if (pcm_valid && !pcm_ready) overrun <= 1'b1;
      else if (overrun_clr)        overrun <= 1'b0;
    end else begin
      if (pcm_valid && pcm_ready) pcm_valid <= 1'b0;
      if (overrun_clr)            overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Bench for pdm_cic_decimator at default parameters: directed PDM windows,
// expected PCM samples queued by the driver and checked by a pop monitor.
module tb_pdm_cic_decimator;

  localparam int OW = 16;

  logic                 wbs_clk_i = 1'b0;
  logic                 wbs_rst_i = 1'b1;
  logic                 pdm_stb = 1'b0;
  logic                 pdm_dat = 1'b0;
  logic signed [OW-1:0] pcm_dat;
  logic                 pcm_valid;
  logic                 pcm_ready = 1'b1;
  logic                 overrun;
  logic                 overrun_clr = 1'b0;

  int total = 0;
  int bad   = 0;
  logic [OW-1:0] exp_q[$];

  pdm_cic_decimator dut (
    .wbs_clk_i  (wbs_clk_i),
    .wbs_rst_i  (wbs_rst_i),
    .pdm_stb    (pdm_stb),
    .pdm_dat    (pdm_dat),
    .pcm_dat    (pcm_dat),
    .pcm_valid  (pcm_valid),
    .pcm_ready  (pcm_ready),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  // clock / reset
  always #5 wbs_clk_i = ~wbs_clk_i;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge wbs_clk_i);
    #1;
  endtask

  task automatic do_reset();
    wbs_rst_i = 1'b1;
    idle(2);
    wbs_rst_i = 1'b0;
  endtask

  // One strobe; returns just after the edge that samples it.
  task automatic do_stb(input logic b);
    pdm_dat = b;
    pdm_stb = 1'b1;
    @(posedge wbs_clk_i);
    #1;
    pdm_stb = 1'b0;
  endtask

  // mode 0: all zeros, 1: all ones, 2: alternating starting with 1
  task automatic window(input int mode, input int n, input bit hold_last);
    for (int i = 0; i < n; i++) begin
      do_stb((mode == 2) ? (i % 2 == 0) : (mode == 1));
      if (!(hold_last && i == n - 1)) idle(7);
    end
  endtask

  task automatic push(input int v);
    exp_q.push_back(OW'(v));
  endtask

  // monitor / scoreboard
  always @(negedge wbs_clk_i) begin
    if (!wbs_rst_i && pcm_valid && pcm_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", int'(pcm_dat), 99999);
      end else begin
        logic [OW-1:0] e;
        e = exp_q.pop_front();
        check("pcm_pop", int'(pcm_dat), int'($signed(e)));
      end
    end
  end

  initial begin
    bit early;
    idle(2);
    wbs_rst_i = 1'b0;
    check("rst_pcm_dat", int'(pcm_dat), 0);
    check("rst_pcm_valid", int'(pcm_valid), 0);
    check("rst_overrun", int'(overrun), 0);

    // Constant +1: transient 2604, 13524, then full scale 16384.
    push(2604); push(13524); push(16384); push(16384);
    repeat (4) window(1, 64, 1'b0);

    do_reset();
    push(-2604); push(-13524); push(-16384); push(-16384);
    repeat (4) window(0, 64, 1'b0);

    do_reset();
    push(62); push(66); push(0); push(0);
    repeat (4) window(2, 64, 1'b0);

    // Latency: valid rises exactly five edges after the decimation strobe.
    do_reset();
    push(2604);
    window(1, 64, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      idle(1);
      check("lat_valid_early", int'(pcm_valid), 0);
      check("lat_dat_early", int'(pcm_dat), 0);
    end
    idle(1);
    check("lat_valid_t5", int'(pcm_valid), 1);
    check("lat_dat_t5", int'(pcm_dat), 2604);
    idle(7);

    // Back-pressure and overrun.
    pcm_ready = 1'b0;
    window(1, 64, 1'b1);
    idle(5);
    check("ovr_first_hold", int'(overrun), 0);
    check("ovr_first_dat", int'(pcm_dat), 13524);
    idle(7);
    window(1, 64, 1'b1);
    idle(5);
    check("ovr_set", int'(overrun), 1);
    check("ovr_dat_second", int'(pcm_dat), 16384);
    check("ovr_valid_kept", int'(pcm_valid), 1);
    overrun_clr = 1'b1;
    idle(1);
    overrun_clr = 1'b0;
    check("ovr_clr", int'(overrun), 0);
    idle(6);
    window(1, 64, 1'b1);
    idle(4);
    overrun_clr = 1'b1;
    idle(1);
    overrun_clr = 1'b0;
    check("ovr_set_wins", int'(overrun), 1);
    overrun_clr = 1'b1;
    idle(1);
    overrun_clr = 1'b0;
    check("ovr_clr2", int'(overrun), 0);
    idle(5);
    push(16384); push(16384);
    window(1, 64, 1'b1);
    idle(4);
    pcm_ready = 1'b1;
    idle(1);
    check("pop_coincide_ovr", int'(overrun), 0);
    check("pop_coincide_valid", int'(pcm_valid), 1);
    idle(7);

    // Reset with a sample in the comb pipeline.
    window(1, 64, 1'b1);
    idle(2);
    wbs_rst_i = 1'b1;
    idle(1);
    check("rst_flight_dat", int'(pcm_dat), 0);
    check("rst_flight_valid", int'(pcm_valid), 0);
    wbs_rst_i = 1'b0;
    early = 1'b0;
    for (int k = 0; k < 12; k++) begin
      idle(1);
      if (pcm_valid) early = 1'b1;
    end
    check("rst_flight_discard", int'(early), 0);

    // Reset mid-window (counter=37): next output after 64 fresh strobes.
    window(1, 37, 1'b0);
    wbs_rst_i = 1'b1;
    idle(1);
    wbs_rst_i = 1'b0;
    push(2604);
    early = 1'b0;
    for (int i = 0; i < 63; i++) begin
      do_stb(1'b1);
      for (int k = 0; k < 7; k++) begin
        idle(1);
        if (pcm_valid) early = 1'b1;
      end
    end
    check("midwin_no_early", int'(early), 0);
    do_stb(1'b1);
    idle(5);
    check("midwin_valid", int'(pcm_valid), 1);
    check("midwin_dat", int'(pcm_dat), 2604);
    idle(7);

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pdm_cic_decimator.md
PDM_CIC_DECIMATOR -- requirements
Module: pdm_cic_decimator

Interface
REQ-001 Parameter ORDER, default 3, number of CIC integrator/comb stages; legal range 1..5.
REQ-002 Parameter DECIMATION, default 64, PDM bits per PCM sample; power of two, at least 2.
REQ-003 Parameter OUT_WIDTH, default 16, PCM output sample width.
REQ-004 Derived constant W = ORDER*log2(DECIMATION)+2 SHALL be the internal two's-complement width; the design SHALL require W >= OUT_WIDTH.
REQ-005 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-006 wbs_clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-007 wbs_rst_i  in  1  synchronous active-high reset.
REQ-008 pdm_stb  in  1  one-cycle strobe; pdm_dat is valid and is sampled on this cycle.
REQ-009 pdm_dat  in  1  PDM bit from the microphone: 1 maps to +1, 0 maps to -1.
REQ-010 pcm_dat  out  OUT_WIDTH  signed PCM sample, registered.
REQ-011 pcm_valid  out  1  pcm_dat holds an untransferred sample.
REQ-012 pcm_ready  in  1  consumer accepts pcm_dat on a cycle where pcm_valid=1 and pcm_ready=1.
REQ-013 overrun  out  1  sticky flag; set when an untransferred sample is overwritten.
REQ-014 overrun_clr  in  1  one-cycle pulse that clears overrun.

Function
REQ-015 Each pdm_stb SHALL add +1 or -1 (per pdm_dat) into integrator 1; integrator k SHALL add the registered output of integrator k-1; all integrators SHALL update on the same edge, W bits, wrap modulo 2^W.
REQ-016 Cycles without pdm_stb SHALL leave the integrators and the decimation counter unchanged.
REQ-017 The decimation counter SHALL count pdm_stb from 0 to DECIMATION-1 and wrap to 0; the strobe that wraps it is the decimation strobe.
REQ-018 On the cycle after a decimation strobe, the last integrator value SHALL be captured, including that strobe's contribution, and launched into the comb pipeline.
REQ-019 Comb stage k SHALL compute y = x - x_prev (W bits, modulo 2^W), store x as x_prev, and take exactly one clock per stage; ORDER stages SHALL be pipelined back to back.
REQ-020 The comb output SHALL be arithmetically shifted right by W-OUT_WIDTH bits (truncation, no rounding) to form pcm_dat.
REQ-021 Latency SHALL be fixed: pcm_dat/pcm_valid update on edge ORDER+2 after the decimation strobe edge.
REQ-022 Consecutive pdm_stb pulses SHALL be at least ORDER+3 cycles apart; behaviour for closer spacing is undefined.
REQ-023 On a transfer (pcm_valid and pcm_ready both high) with no new sample that cycle, pcm_valid SHALL fall on the next edge.
REQ-024 On a new sample with pcm_valid=0, or with pcm_valid=1 and pcm_ready=1 on the same cycle: load pcm_dat, pcm_valid=1, overrun unchanged.
REQ-025 On a new sample with pcm_valid=1 and pcm_ready=0: overwrite pcm_dat, keep pcm_valid=1, set overrun=1.
REQ-026 If overrun_clr and an overrun-setting event occur on the same cycle, the set SHALL win.
REQ-027 pcm_ready SHALL have no effect while pcm_valid=0; pcm_dat SHALL be stable while pcm_valid=1 and no new sample arrives.

Reset
REQ-028 wbs_rst_i SHALL clear all integrators, comb delay registers, the pipeline, and the decimation counter; it SHALL also set pcm_dat=0, pcm_valid=0, overrun=0.
REQ-029 Reset SHALL take priority over every other input on the same edge and SHALL discard any sample in flight in the comb pipeline.
REQ-030 After reset, the first decimation strobe SHALL be the DECIMATION-th pdm_stb following reset release.

Verification
REQ-031 Defaults, pdm_dat held 1, strobe every 8 cycles, pcm_ready=1 -> from the 3rd output onward pcm_dat=16384 (0x4000) on every output.
REQ-032 Defaults, pdm_dat held 0 -> steady-state pcm_dat=-16384 (0xC000); alternating 1/0 -> steady-state pcm_dat=0.
REQ-033 Single decimation strobe at edge T -> pcm_valid rises exactly at edge T+5 (ORDER=3); no earlier change of pcm_dat.
REQ-034 pcm_ready=0 across two outputs -> overrun=1 and pcm_dat holds the 2nd sample; overrun_clr pulse -> overrun=0; new sample coinciding with a pop -> overrun stays 0.
REQ-035 Assert wbs_rst_i mid-window (counter=37) with a sample in the comb pipeline -> all outputs 0 next edge, pcm_valid never rises for the discarded sample, next output only after 64 fresh strobes.
REQ-036 Overrun set and overrun_clr on the same cycle -> overrun=1.
